// File: rtl/matrix_mult_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : matrix_mult_seq_pkg
//  Description : Shared constants and helpers for the sequential N x N
//                matrix multiplier (default sizes, index width, and the
//                element bit-offset used by the row-major packing).
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package matrix_mult_seq_pkg;

    localparam int c_N_DEF = 3;   // default matrix dimension
    localparam int c_M_DEF = 32;  // default element width

    // Width needed to hold values 0..n-1, never less than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // LSB position of element (r,c); row-major, (0,0) in the LSBs.
    function automatic int elem_lsb(input int r, input int c, input int n, input int m);
        return (r * n + c) * m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/matrix_mult_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : matrix_mult_seq_ctrl
//  Description : Row/column/inner index counters for the sequential matrix
//                multiplier. k sweeps fastest; when k reaches N-1 the
//                (row,col) pair advances in row-major order and wraps.
//  Ports       : clk, rst       - clock, synchronous active-high reset
//                o_row, o_col   - current output element indices (i, j)
//                o_inner        - current inner-product index (k)
//                o_last_k       - high on the cycle that completes (i,j)
//  Revision    : 1.0 - initial release
// ============================================================================
module matrix_mult_seq_ctrl
    import matrix_mult_seq_pkg::*;
#(
    parameter int N  = c_N_DEF,
    parameter int IW = idx_width(N)
) (
    input  logic          clk,
    input  logic          rst,
    output logic [IW-1:0] o_row,
    output logic [IW-1:0] o_col,
    output logic [IW-1:0] o_inner,
    output logic          o_last_k
);

    localparam logic [IW-1:0] c_LAST = IW'(N - 1);

    logic [IW-1:0] r_row;
    logic [IW-1:0] r_col;
    logic [IW-1:0] r_inner;
    logic          w_last_k;

    assign w_last_k = (r_inner == c_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_row   <= '0;
            r_col   <= '0;
            r_inner <= '0;
        end else if (w_last_k) begin
            r_inner <= '0;
            if (r_col == c_LAST) begin
                r_col <= '0;
                r_row <= (r_row == c_LAST) ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end else begin
            r_inner <= r_inner + 1'b1;
        end
    end

    assign o_row    = r_row;
    assign o_col    = r_col;
    assign o_inner  = r_inner;
    assign o_last_k = w_last_k;

endmodule
`default_nettype wire

// File: rtl/matrix_mult_seq.sv
`default_nettype none
// ============================================================================
//  Module      : matrix_mult_seq
//  Description : Free-running sequential N x N matrix multiplier, o = x * y,
//                modulo 2^M. One scalar multiply-accumulate per clock; a full
//                product takes N^3 cycles and then restarts on current inputs.
//  Ports       : clk  - clock (rising edge)
//                rst  - synchronous active-high reset (clears o and state)
//                x    - left operand, M*N*N bits, row-major packed
//                y    - right operand, M*N*N bits, row-major packed
//                o    - registered product, M*N*N bits, row-major packed
//  Revision    : 1.0 - initial release
// ============================================================================
module matrix_mult_seq
    import matrix_mult_seq_pkg::*;
#(
    parameter int N = c_N_DEF,
    parameter int M = c_M_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [M*N*N-1:0] x,
    input  logic [M*N*N-1:0] y,
    output logic [M*N*N-1:0] o
);

    localparam int c_IW = idx_width(N);
    localparam int c_PW = idx_width(M * N * N);  // bit-offset width into x/y/o

    logic [c_IW-1:0] w_row;
    logic [c_IW-1:0] w_col;
    logic [c_IW-1:0] w_inner;
    logic            w_last_k;

    logic [c_PW-1:0] w_x_lsb;
    logic [c_PW-1:0] w_y_lsb;
    logic [c_PW-1:0] w_o_lsb;
    logic [M-1:0]    w_xe;
    logic [M-1:0]    w_ye;
    logic [M-1:0]    w_prod;
    logic [M-1:0]    w_sum;
    logic [M-1:0]    r_acc;

    matrix_mult_seq_ctrl #(
        .N  (N),
        .IW (c_IW)
    ) u_ctrl (
        .clk      (clk),
        .rst      (rst),
        .o_row    (w_row),
        .o_col    (w_col),
        .o_inner  (w_inner),
        .o_last_k (w_last_k)
    );

    // Operands x(i,k) and y(k,j) are selected combinationally every cycle.
    assign w_x_lsb = c_PW'(elem_lsb(int'(w_row),   int'(w_inner), N, M));
    assign w_y_lsb = c_PW'(elem_lsb(int'(w_inner), int'(w_col),   N, M));
    assign w_o_lsb = c_PW'(elem_lsb(int'(w_row),   int'(w_col),   N, M));

    assign w_xe = x[w_x_lsb +: M];
    assign w_ye = y[w_y_lsb +: M];

    // Low M bits of the product are sign-agnostic, so unsigned is enough.
    assign w_prod = w_xe * w_ye;
    assign w_sum  = r_acc + w_prod;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
        end else if (w_last_k) begin
            r_acc <= '0;
        end else begin
            r_acc <= w_sum;
        end
    end

    // Only the element just completed is written; the rest hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            o <= '0;
        end else if (w_last_k) begin
            o[w_o_lsb +: M] <= w_sum;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_matrix_mult_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_matrix_mult_seq
//  Description : Self-checking bench for matrix_mult_seq (N=3, M=32) with a
//                behavioural matrix-product reference model.
//  Ports       : none
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_matrix_mult_seq;

    localparam int c_N = 3;
    localparam int c_M = 32;
    localparam int c_W = c_M * c_N * c_N;
    localparam int c_FULL = c_N * c_N * c_N;

    logic           clk;
    logic           rst;
    logic [c_W-1:0] x;
    logic [c_W-1:0] y;
    logic [c_W-1:0] o;

    int n_assert;
    int n_fail;

    matrix_mult_seq #(
        .N (c_N),
        .M (c_M)
    ) dut (
        .clk (clk),
        .rst (rst),
        .x   (x),
        .y   (y),
        .o   (o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: element e of x*y is complete after (e+1)*N clocks from a
    // clean start; elements not yet reached read as zero.
    function automatic logic [c_W-1:0] ref_mult(input logic [c_W-1:0] a,
                                                 input logic [c_W-1:0] b,
                                                 input int cycles);
        logic [c_W-1:0] res;
        logic [31:0]    s;
        res = '0;
        for (int r = 0; r < c_N; r++) begin
            for (int c = 0; c < c_N; c++) begin
                s = 32'd0;
                for (int k = 0; k < c_N; k++)
                    s = s + a[(r*c_N+k)*c_M +: c_M] * b[(k*c_N+c)*c_M +: c_M];
                if (cycles >= (r*c_N + c + 1) * c_N)
                    res[(r*c_N+c)*c_M +: c_M] = s;
            end
        end
        return res;
    endfunction

    function automatic logic [c_W-1:0] fill(input logic [31:0] v);
        logic [c_W-1:0] res;
        for (int e = 0; e < c_N*c_N; e++) res[e*c_M +: c_M] = v;
        return res;
    endfunction

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [c_W-1:0] exp);
        logic [31:0] got_e;
        logic [31:0] exp_e;
        for (int e = 0; e < c_N*c_N; e++) begin
            got_e = o[e*c_M +: c_M];
            exp_e = exp[e*c_M +: c_M];
            n_assert++;
            assert (got_e === exp_e) else begin
                n_fail++;
                $error("FAIL %s elem(%0d,%0d): observed %0h expected %0h",
                       tag, e / c_N, e % c_N, got_e, exp_e);
            end
        end
    endtask

    logic [c_W-1:0] xs, ys;

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst = 1'b1;
        // Sequential operands: x = 1..9, y = 9..1
        for (int e = 0; e < 9; e++) begin
            x[e*c_M +: c_M] = 32'(e + 1);
            y[e*c_M +: c_M] = 32'(9 - e);
        end
        step(2);
        check("reset", '0);

        // Incremental fill from reset release
        rst = 1'b0;
        step(2);  check("fill_2",  ref_mult(x, y, 2));
        step(1);  check("fill_3",  ref_mult(x, y, 3));
        step(3);  check("fill_6",  ref_mult(x, y, 6));
        step(20); check("fill_26", ref_mult(x, y, 26));
        step(1);  check("seq_full", ref_mult(x, y, c_FULL));
        xs = '0;
        xs[0 +: 32]   = 32'd30;  xs[32 +: 32]  = 32'd24;  xs[64 +: 32]  = 32'd18;
        xs[96 +: 32]  = 32'd84;  xs[128 +: 32] = 32'd69;  xs[160 +: 32] = 32'd54;
        xs[192 +: 32] = 32'd138; xs[224 +: 32] = 32'd114; xs[256 +: 32] = 32'd90;
        check("seq_const", xs);

        // Reset mid-pass at cycle 10
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        step(10);
        rst = 1'b1;
        step(1);  check("midrst_clear", '0);
        rst = 1'b0;
        step(c_FULL - 1); check("midrst_26", ref_mult(x, y, c_FULL - 1));
        step(1);          check("midrst_full", ref_mult(x, y, c_FULL));

        // Identity x random y, two passes
        rst = 1'b1;
        x = '0;
        for (int d = 0; d < c_N; d++) x[(d*c_N+d)*c_M +: c_M] = 32'd1;
        for (int e = 0; e < 9; e++) y[e*c_M +: c_M] = $urandom;
        step(1);
        rst = 1'b0;
        step(c_FULL); check("ident_p1", y);
        step(c_FULL); check("ident_p2", y);

        // Overflow: all 0xFFFFFFFF
        rst = 1'b1;
        x = fill(32'hFFFF_FFFF);
        y = fill(32'hFFFF_FFFF);
        step(1);
        rst = 1'b0;
        step(c_FULL); check("ovf", fill(32'h3));

        // Random operands, several passes
        for (int t = 0; t < 4; t++) begin
            rst = 1'b1;
            for (int e = 0; e < 9; e++) begin
                x[e*c_M +: c_M] = $urandom;
                y[e*c_M +: c_M] = (t == 0) ? 32'($urandom_range(0, 15)) : $urandom;
            end
            step(1);
            rst = 1'b0;
            step(c_FULL); check("rand", ref_mult(x, y, c_FULL));
        end

        // All ones, then x switched to all twos between passes
        rst = 1'b1;
        x = fill(32'd1);
        y = fill(32'd1);
        step(1);
        rst = 1'b0;
        step(c_FULL); check("ones", fill(32'd3));
        x = fill(32'd2);
        step(c_N);    check("twos_partial", {fill(32'd3)} & ~{{(c_W-c_M){1'b0}}, {c_M{1'b1}}} | {{(c_W-c_M){1'b0}}, 32'd6});
        step(c_FULL - c_N); check("twos", fill(32'd6));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/matrix_mult_seq.md
Name: matrix_mult_seq

Overview:
- Sequential N×N matrix multiplier: o = x · y over M-bit elements, arithmetic modulo 2^M.
- A single multiply-accumulate datapath performs one scalar product per clock, so a full result takes N³ cycles.
- Free-running compute block: no start/done handshake; recomputes continuously from its flat, bus-packed matrix inputs.

Parameters:
- N, 3, matrix dimension (rows = columns); N ≥ 1.
- M, 32, element width in bits.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- x  input  M*N*N  left operand matrix, packed.
- y  input  M*N*N  right operand matrix, packed.
- o  output  M*N*N  product matrix, packed, registered.

Behaviour:
- Packing, same for x, y, o: element (r,c) occupies bits [(r*N+c)*M +: M]. Row-major, element (0,0) in the LSBs.
- State:
  - index counters i (row), j (column), k (inner), each 0..N-1;
  - accumulator acc, M bits;
  - output register o.
- Reset (rst=1 at a rising edge): i=j=k=0, acc=0, o=0 (all bits). Reset has priority over compute.
- Each non-reset cycle:
  - p = (x(i,k) * y(k,j)) mod 2^M, unsigned. Low M bits are identical for two's-complement operands.
  - If k < N-1: acc <= acc + p (mod 2^M); k <= k+1.
  - If k == N-1: o(i,j) <= acc + p (mod 2^M); acc <= 0; k <= 0; advance (i,j) in row-major order (j increments, wrapping to 0 with i incrementing).
- Wrap: after (N-1,N-1) completes, i, j, k return to 0 and computation restarts on the current x, y. o keeps its old elements until each is overwritten.
- Latency: element (r,c) is written at the rising edge ending cycle (r*N+c)*N + N-1, counting from cycle 0 = first cycle after reset release. The full matrix is valid after N³ cycles (27 for N=3).
- Operands are read combinationally every cycle. x and y must be held stable for N³ cycles for a coherent result. Changing them mid-pass gives a mix of old and new products; this is defined, not an error.
- Reset mid-operation: aborts the pass, clears o and acc, restarts at (0,0,0).
- Only o(i,j) changes per write; all other o elements hold.
- No internal overflow detection; all sums and products are truncated to M bits.

Decomposition:
- Shared package:
  - defaults N=3, M=32;
  - index-width constant $clog2(N) (minimum 1);
  - helper function elem_lsb(r,c) = (r*N+c)*M.
- One natural sub-module, matrix_mult_seq_ctrl: the i/j/k counters plus the "last_k" strobe.
- The datapath (operand muxes, multiplier, accumulator, output write) stays in the top.

Test Plan:
- Sequential 1..9 × 9..1: x rows [1,2,3],[4,5,6],[7,8,9]; y rows [9,8,7],[6,5,4],[3,2,1]; release rst, run 27 cycles -> o rows [30,24,18],[84,69,54],[138,114,90].
- Identity × arbitrary: x = I, y = random 32-bit elements -> after 27 cycles o == y; a second 27-cycle pass gives the same o.
- Overflow: all x, y elements 0xFFFFFFFF -> every product is 1 mod 2^32, so every o element = 0x00000003.
- Incremental fill: after reset with the 1..9/9..1 operands:
  - after cycle 3, o(0,0)=30 and all other elements are 0;
  - after cycle 6, o(0,1)=24;
  - o(2,2)=90 first appears after cycle 27.
- Reset mid-pass: assert rst for 1 cycle at cycle 10 -> o = 0 on the following edge; the full correct result appears 27 cycles after release.
- All-ones: all elements 1 -> every o element = 3 after 27 cycles. Then change x to all 2 and run 27 more cycles -> every o element = 6.
